// File: rtl/lbm_sweep_ctrl.sv
// lbm_sweep_ctrl: raster-sweeps an NX x NY lattice, emitting per-node streaming neighbour addresses and bounce flags.
module lbm_sweep_ctrl #(
  parameter int NX = 16,
  parameter int NY = 16,
  parameter int Q = 9,
  parameter int ADDRESS_WIDTH = $clog2(NX*NY),
  parameter int ITER_WIDTH = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       start,
  input  logic [ITER_WIDTH-1:0]      num_iter,
  input  logic                       boundary_mode,
  input  logic                       node_ready,
  output logic                       node_valid,
  output logic [ADDRESS_WIDTH-1:0]   node_addr,
  output logic [Q*ADDRESS_WIDTH-1:0] nbr_addr,
  output logic [Q-1:0]               bounce,
  output logic                       buf_sel,
  output logic [ITER_WIDTH-1:0]      iter_count,
  output logic                       busy,
  output logic                       done
);
  localparam int XW = NX > 1 ? $clog2(NX) : 1;
  localparam int YW = NY > 1 ? $clog2(NY) : 1;
  localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, ITER_END = 2'd2, DONE = 2'd3;
  localparam int DX [0:8] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int DY [0:8] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  logic [1:0] state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [ITER_WIDTH-1:0] num_r, cnt_n;
  logic mode_r, mode_n, upd, last, accept;
  logic [Q*ADDRESS_WIDTH-1:0] nbr_n;
  logic [Q-1:0] bounce_n;
  function automatic logic [ADDRESS_WIDTH:0] nbr(input int cx, input int cy, input int dx, input int dy, input logic m);
    int tx, ty;
    tx = cx + dx;
    ty = cy + dy;
    if (m && (tx < 0 || tx >= NX || ty < 0 || ty >= NY)) return {1'b1, ADDRESS_WIDTH'(cy*NX + cx)};
    tx = tx < 0 ? tx + NX : tx >= NX ? tx - NX : tx;
    ty = ty < 0 ? ty + NY : ty >= NY ? ty - NY : ty;
    return {1'b0, ADDRESS_WIDTH'(ty*NX + tx)};
  endfunction
  assign node_valid = state == SWEEP;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // descriptor for the node about to be presented is computed from the next coordinates and registered
  always_comb begin
    accept = node_valid && node_ready;
    last = x == XW'(NX-1) && y == YW'(NY-1);
    cnt_n = iter_count + 1'b1;
    mode_n = state == IDLE ? boundary_mode : mode_r;
    upd = (state == IDLE && start && num_iter != '0) || (state == ITER_END && cnt_n != num_r) || (accept && !last);
    nx = accept && !last ? (x == XW'(NX-1) ? '0 : x + 1'b1) : '0;
    ny = accept && !last ? (x == XW'(NX-1) ? y + 1'b1 : y) : '0;
    nbr_n = '0;
    bounce_n = '0;
    for (int i = 0; i < Q; i++)
      {bounce_n[i], nbr_n[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]} = nbr(int'(nx), int'(ny), DX[i], DY[i], mode_n);
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      num_r <= '0;
      mode_r <= 1'b0;
      node_addr <= '0;
      nbr_addr <= '0;
      bounce <= '0;
      buf_sel <= 1'b0;
      iter_count <= '0;
    end else begin
      if (upd) begin
        x <= nx;
        y <= ny;
        node_addr <= nbr_n[ADDRESS_WIDTH-1:0];
        nbr_addr <= nbr_n;
        bounce <= bounce_n;
      end
      case (state)
        IDLE: if (start) begin
          num_r <= num_iter;
          mode_r <= boundary_mode;
          iter_count <= '0;
          buf_sel <= 1'b0;
          state <= num_iter == '0 ? DONE : SWEEP;
        end
        SWEEP: if (accept && last) state <= ITER_END;
        ITER_END: begin
          iter_count <= cnt_n;
          buf_sel <= ~buf_sel;
          state <= cnt_n == num_r ? DONE : SWEEP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// tb_lbm_sweep_ctrl: scoreboard bench; stimulus queues expected beats/done pulses, a negedge monitor checks them.
module tb_lbm_sweep_ctrl;
  logic clk = 0, rst_n = 0, start = 0, boundary_mode = 0, node_ready = 1;
  logic [15:0] num_iter = 0;
  logic node_valid, buf_sel, busy, done;
  logic [7:0] node_addr;
  logic [71:0] nbr_addr;
  logic [8:0] bounce;
  logic [15:0] iter_count;
  int cyc = 0, n_vec = 0, n_bad = 0;
  bit cur_mode;
  typedef struct {int addr; bit bs; int cyc;} beat_t;
  typedef struct {int cyc; int it; bit bs;} done_t;
  typedef struct {bit mode; int addr; logic [71:0] nbr; logic [8:0] b;} vec_t;
  beat_t exp_q[$];
  done_t done_q[$];
  vec_t vecs[7];
  logic [88:0] prev_desc;
  bit hold_prev = 0;

  lbm_sweep_ctrl dut (.CLOCK_50(clk), .RESET(rst_n), .start(start), .num_iter(num_iter),
    .boundary_mode(boundary_mode), .node_ready(node_ready), .node_valid(node_valid),
    .node_addr(node_addr), .nbr_addr(nbr_addr), .bounce(bounce), .buf_sel(buf_sel),
    .iter_count(iter_count), .busy(busy), .done(done));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    done_t d;
    if (node_valid) begin
      if (hold_prev) chk("hold", {node_addr, nbr_addr, bounce}, prev_desc);
      if (node_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_beat: node %0d accepted with nothing expected", node_addr);
        end else begin
          e = exp_q.pop_front();
          chk("node_addr", node_addr, e.addr);
          chk("buf_sel", buf_sel, e.bs);
          if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
          foreach (vecs[i])
            if (vecs[i].mode == cur_mode && vecs[i].addr == e.addr) begin
              chk("nbr_addr", nbr_addr, vecs[i].nbr);
              chk("bounce", bounce, vecs[i].b);
            end
        end
      end
    end
    hold_prev = node_valid && !node_ready;
    prev_desc = {node_addr, nbr_addr, bounce};
    if (done) begin
      if (done_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done pulse at cycle %0d", cyc);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_iter_count", iter_count, d.it);
        chk("done_buf_sel", buf_sel, d.bs);
      end
    end
  end

  task automatic do_start(input int n, input bit m, output int s);
    @(posedge clk);
    #1 num_iter = 16'(n);
    boundary_mode = m;
    cur_mode = m;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    s = cyc;
    num_iter = 16'd9;
    boundary_mode = ~m;
  endtask

  task automatic push_beats(input int sweeps, input int s, input bit timed);
    for (int k = 0; k < sweeps; k++)
      for (int a = 0; a < 256; a++)
        exp_q.push_back('{a, k[0], timed ? s + k*257 + a : -1});
  endtask

  task automatic wait_empty(input string nm);
    int i;
    for (i = 0; i < 2000 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
    if (i == 2000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: beats left %0d, dones left %0d, required 0", nm, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_node(input int a);
    int i;
    for (i = 0; i < 600 && !(node_valid && node_addr == 8'(a)); i++) @(negedge clk);
    if (i == 600) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_node: node %0d never presented", a);
    end
  endtask

  initial begin
    int s;
    vecs[0] = '{0, 0,   {8'd241, 8'd255, 8'd31, 8'd17, 8'd240, 8'd15, 8'd16, 8'd1, 8'd0}, 9'b0};
    vecs[1] = '{0, 17,  {8'd2, 8'd0, 8'd32, 8'd34, 8'd1, 8'd16, 8'd33, 8'd18, 8'd17}, 9'b0};
    vecs[2] = '{0, 255, {8'd224, 8'd238, 8'd14, 8'd0, 8'd239, 8'd254, 8'd15, 8'd240, 8'd255}, 9'b0};
    vecs[3] = '{1, 0,   {8'd0, 8'd0, 8'd0, 8'd17, 8'd0, 8'd0, 8'd16, 8'd1, 8'd0}, 9'b111011000};
    vecs[4] = '{1, 15,  {8'd15, 8'd15, 8'd30, 8'd15, 8'd15, 8'd14, 8'd31, 8'd15, 8'd15}, 9'b110110010};
    vecs[5] = '{1, 255, {8'd255, 8'd238, 8'd255, 8'd255, 8'd239, 8'd254, 8'd255, 8'd255, 8'd255}, 9'b101100110};
    vecs[6] = '{1, 17,  {8'd2, 8'd0, 8'd32, 8'd34, 8'd1, 8'd16, 8'd33, 8'd18, 8'd17}, 9'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {node_valid, node_addr, nbr_addr, bounce, buf_sel, iter_count, busy, done}, 0);
    rst_n = 1;
    // periodic single sweep, timed, with an ignored start pulse mid-run
    do_start(1, 0, s);
    push_beats(1, s, 1);
    done_q.push_back('{s + 257, 1, 1});
    wait_node(100);
    @(posedge clk);
    #1 start = 1;
    num_iter = 16'd7;
    boundary_mode = 1;
    @(posedge clk);
    #1 start = 0;
    wait_empty("periodic");
    // bounce-back sweep with backpressure on node 5
    do_start(1, 1, s);
    push_beats(1, s, 0);
    done_q.push_back('{s + 257 + 3, 1, 1});
    wait_node(4);
    @(posedge clk);
    #1 node_ready = 0;
    repeat (3) @(posedge clk);
    #1 node_ready = 1;
    wait_empty("bounce");
    // three sweeps: buf_sel alternates, final count 3
    do_start(3, 0, s);
    push_beats(3, s, 1);
    done_q.push_back('{s + 3*257, 3, 1});
    wait_empty("three_iter");
    // reset in mid-sweep aborts with no done pulse
    do_start(2, 0, s);
    push_beats(2, s, 1);
    wait_node(10);
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("midrun_reset_1", {node_valid, node_addr, nbr_addr, bounce, buf_sel, iter_count, busy, done}, 0);
    @(negedge clk);
    chk("midrun_reset_2", {node_valid, node_addr, nbr_addr, bounce, buf_sel, iter_count, busy, done}, 0);
    rst_n = 1;
    repeat (5) @(posedge clk);
    // zero iterations: done right after the start edge, no beats
    do_start(0, 0, s);
    done_q.push_back('{s, 0, 0});
    wait_empty("zero_iter");
    chk("queues_empty", exp_q.size() + done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lbm_sweep_ctrl.md
LBM_SWEEP_CTRL -- requirements
Module: lbm_sweep_ctrl

Interface
REQ-001 SHALL have parameter NX, default 16, grid width in nodes.
REQ-002 SHALL have parameter NY, default 16, grid height in nodes.
REQ-003 SHALL have parameter Q, default 9, lattice direction count; legal values are 5 (D2Q5) and 9 (D2Q9).
REQ-004 SHALL have parameter ADDRESS_WIDTH, default $clog2(NX*NY), node address width.
REQ-005 SHALL have parameter ITER_WIDTH, default 16, iteration counter width.
REQ-006 CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-007 RESET  input  1  reset, synchronous and active-low.
REQ-008 start  input  1  pulse; begins a run when the block is idle.
REQ-009 num_iter  input  ITER_WIDTH  number of full grid sweeps; sampled at start.
REQ-010 boundary_mode  input  1  0 = periodic, 1 = bounce-back; sampled at start.
REQ-011 node_ready  input  1  downstream accepts the current node.
REQ-012 node_valid  output  1  node descriptor is valid.
REQ-013 node_addr  output  ADDRESS_WIDTH  current node address, y*NX+x.
REQ-014 nbr_addr  output  Q*ADDRESS_WIDTH  streaming destination per direction; direction i occupies slice i.
REQ-015 bounce  output  Q  per-direction bounce-back flag.
REQ-016 buf_sel  output  1  ping-pong distribution buffer select.
REQ-017 iter_count  output  ITER_WIDTH  completed sweeps in the current run.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  single-cycle pulse at end of run.

Function
REQ-020 Direction order SHALL be 0 rest, 1 E(+1,0), 2 N(0,+1), 3 W(-1,0), 4 S(0,-1), 5 NE, 6 NW, 7 SW, 8 SE; Q=5 uses 0-4 only.
REQ-021 FSM states SHALL be IDLE, SWEEP, ITER_END, DONE.
REQ-022 IDLE with start=1 SHALL latch num_iter and boundary_mode, clear iter_count and buf_sel, and go to SWEEP at node 0; if num_iter=0 it SHALL go to DONE instead.
REQ-023 start SHALL be ignored outside IDLE; num_iter and boundary_mode changes mid-run SHALL have no effect.
REQ-024 SWEEP SHALL assert node_valid, and the node SHALL advance in raster order (x fastest) only on node_valid && node_ready.
REQ-025 While node_valid=1 and node_ready=0, all descriptor outputs SHALL hold stable.
REQ-026 Acceptance of node NX*NY-1 SHALL move to ITER_END, with node_valid=0 in ITER_END.
REQ-027 ITER_END SHALL increment iter_count, toggle buf_sel, and go to DONE if the new count equals num_iter, else to SWEEP at node 0.
REQ-028 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-029 nbr_addr slice 0 SHALL equal node_addr, and bounce[0] SHALL be 0.
REQ-030 In periodic mode, neighbour coordinates SHALL wrap modulo NX and NY, and bounce SHALL be all-zero.
REQ-031 In bounce-back mode, a direction whose neighbour lies outside the grid SHALL output nbr_addr=node_addr with bounce[i]=1; in-grid directions SHALL use the unwrapped address with bounce[i]=0.
REQ-032 Descriptor outputs SHALL be registered and consistent with node_addr in the same cycle.
REQ-033 With node_ready held high, a run SHALL take exactly num_iter*(NX*NY+1)+1 cycles from the start edge to the done pulse.

Reset
REQ-034 RESET=0 at a clock edge SHALL force IDLE, and node_valid, node_addr, nbr_addr, bounce, buf_sel, iter_count, busy and done SHALL all be 0.
REQ-035 Reset mid-run SHALL abort the run with no done pulse, and the next start SHALL behave as from power-up.

Verification
REQ-036 Reset: hold RESET=0 for 2 cycles mid-SWEEP -> all outputs 0 next cycle, state IDLE, no done.
REQ-037 Periodic, num_iter=1, ready=1, start at cycle 0 -> valid cycles 1-256, ITER_END at 257, done at 258; node 0 gives E=1, N=16, W=15, S=240, NE=17, SW=255, bounce=0.
REQ-038 Bounce-back, node 255 -> E/N/NE/NW/SE = 255 with bounce set; W=254, S=239, SW=238 with bounce clear.
REQ-039 Backpressure: node_ready=0 for 3 cycles while node_addr=5 -> node_addr and nbr_addr hold for 4 cycles, then node 6 follows with no node skipped or repeated.
REQ-040 num_iter=3 -> buf_sel sequence 0,1,0,1 across sweeps, final iter_count=3, done one cycle after the third ITER_END.
REQ-041 num_iter=0 -> done on cycle 1 with no valid beats; start pulsed during SWEEP -> ignored, beat count unchanged.
